micro_sequencer: RTL
====================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, meaning max cycles held in any wait state before timeout (range 1-255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: advance enable; low freezes all state, including the wait counter.
REQ-005 SHALL have port ir_opcode, input, 5 bits: instruction-register opcode field.
REQ-006 SHALL have port hit, input, 1 bit: memory transaction complete.
REQ-007 SHALL have port zero, input, 1 bit: accumulator-zero flag.
REQ-008 SHALL have port addr_ins, output, 9 bits, registered: microinstruction address driven to the control unit.
REQ-009 SHALL have port instr_done, output, 1 bit: one-cycle pulse on return to FETCH1 after an executed instruction.
REQ-010 SHALL have port illegal, output, 1 bit: one-cycle pulse when the latched opcode is not in the table.
REQ-011 SHALL have port halted, output, 1 bit: high while addr_ins = HALT.
REQ-012 SHALL have port timeout, output, 1 bit: sticky flag indicating a wait limit was exceeded.

Function
REQ-013 SHALL run the fetch sequence 000000000 -> 000000010 (wait) -> 100000010 -> 100000011 -> INCPC 000000001 -> execute.
REQ-014 SHALL latch ir_opcode into an internal op register on the cycle addr_ins = 100000011.
REQ-015 SHALL form linear execute addresses as {1'b0, op, step}, with step counting 0..N-1, then return to FETCH1.
REQ-016 SHALL use these step counts N: 11010/01010/11001/01011/00011/00101/00100/10100/10101 = 2; 11011 = 3; 10001/10010 = 4; 01101 = 1.
REQ-017 SHALL run LOAD (op 11100) as 011100000 -> 011100110 (wait) -> 111100110 -> 111100010 -> 111100011 -> FETCH1.
REQ-018 SHALL run STORE (op 11101) as 011101000 -> 011101001 -> 011101010 -> 011101011 (wait) -> FETCH1.
REQ-019 SHALL run GOTOZ (op 10110) from 010110000, sampling zero in that cycle: zero = 1 -> 010110001, zero = 0 -> 110110001; either path then -> FETCH1.
REQ-020 SHALL, for HALT (op 11111), go to 011111111 and hold there until reset; halted = 1.
REQ-021 SHALL hold each wait state (000000010, 011100110, 011101011) until hit = 1 is sampled, then advance on the next edge.
REQ-022 SHALL count cycles in a wait state with an 8-bit counter, cleared on wait entry.
REQ-023 SHALL, when the wait counter reaches WAIT_LIMIT without hit, go to HALT and set timeout.
REQ-024 SHALL give hit priority when hit and timeout occur in the same cycle (normal advance).
REQ-025 SHALL, for an undefined opcode, pulse illegal during INCPC and go INCPC -> FETCH1 with no instr_done.
REQ-026 SHALL, when en = 0, hold addr_ins, step and the wait counter, drop instr_done/illegal to 0, and ignore hit.
REQ-027 SHALL keep every addr_ins transition at exactly one cycle per microstep, except wait states.

Reset
REQ-028 SHALL, while reset = 1, immediately force addr_ins = 000000000, step = 0, op = 00000, wait counter = 0, and instr_done, illegal, halted, timeout = 0.
REQ-029 SHALL, on reset mid-instruction or mid-wait, abandon the instruction with no instr_done and restart at FETCH1 on the first edge after reset drops.

Verification
REQ-030 SHALL cover: reset, then fetch ADD (ir_opcode 01010) with hit on the 3rd wait cycle -> addr_ins 0,2,2,2,0x102,0x103,1,0x050,0x051,0; instr_done in the last cycle.
REQ-031 SHALL cover: LOAD with hit 5 cycles late -> 0x0E6 held 6 cycles, then 0x1E6, 0x1E2, 0x1E3, 0.
REQ-032 SHALL cover: GOTOZ with zero = 0, then with zero = 1 -> 0x1B1, then 0x0B1 respectively.
REQ-033 SHALL cover: WAIT_LIMIT = 4 with hit never asserted in fetch -> addr_ins 0x0FF, timeout = 1, halted = 1.
REQ-034 SHALL cover: opcode 00000 -> illegal pulse during INCPC, next addr_ins 0, no instr_done.
REQ-035 SHALL cover: en low for 3 cycles mid-ADDL, plus reset asserted mid-STORE -> address frozen during en low; after reset, addr_ins = 0 immediately.

Source files
------------

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microinstruction address sequencer with fetch, execute and bounded wait states
module micro_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [4:0] ir_opcode,
  input  logic       hit,
  input  logic       zero,
  output logic [8:0] addr_ins,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted,
  output logic       timeout
);

  localparam logic [8:0] FETCH1     = 9'h000;
  localparam logic [8:0] INCPC      = 9'h001;
  localparam logic [8:0] FETCH_WAIT = 9'h002;
  localparam logic [8:0] FETCH3     = 9'h102;
  localparam logic [8:0] FETCH4     = 9'h103;
  localparam logic [8:0] LOAD0      = 9'h0E0;
  localparam logic [8:0] LOAD_WAIT  = 9'h0E6;
  localparam logic [8:0] LOAD_R1    = 9'h1E6;
  localparam logic [8:0] LOAD_R2    = 9'h1E2;
  localparam logic [8:0] LOAD_R3    = 9'h1E3;
  localparam logic [8:0] STORE0     = 9'h0E8;
  localparam logic [8:0] STORE1     = 9'h0E9;
  localparam logic [8:0] STORE2     = 9'h0EA;
  localparam logic [8:0] STORE_WAIT = 9'h0EB;
  localparam logic [8:0] GOTOZ0     = 9'h0B0;
  localparam logic [8:0] GOTOZ_Z    = 9'h0B1;
  localparam logic [8:0] GOTOZ_NZ   = 9'h1B1;
  localparam logic [8:0] HALT       = 9'h0FF;

  localparam logic [4:0] OP_LOAD  = 5'b11100;
  localparam logic [4:0] OP_STORE = 5'b11101;
  localparam logic [4:0] OP_GOTOZ = 5'b10110;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  // Number of linear execute steps; zero marks an opcode with a custom or no routine.
  function automatic logic [2:0] lin_steps(input logic [4:0] o);
    case (o)
      5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
      5'b00101, 5'b00100, 5'b10100, 5'b10101: return 3'd2;
      5'b11011:                               return 3'd3;
      5'b10001, 5'b10010:                     return 3'd4;
      5'b01101:                               return 3'd1;
      default:                                return 3'd0;
    endcase
  endfunction

  function automatic logic op_valid(input logic [4:0] o);
    return (lin_steps(o) != 3'd0) || (o == OP_LOAD) || (o == OP_STORE) ||
           (o == OP_GOTOZ) || (o == OP_HALT);
  endfunction

  logic [4:0] op, next_op;
  logic [2:0] step, next_step;
  logic [7:0] wait_cnt, next_cnt;
  logic [8:0] next_addr;
  logic       next_done, next_ill, next_to, in_wait;

  assign in_wait = (addr_ins == FETCH_WAIT) || (addr_ins == LOAD_WAIT) || (addr_ins == STORE_WAIT);
  assign halted  = (addr_ins == HALT);

  always_comb begin
    next_addr = addr_ins;
    next_op   = op;
    next_step = step;
    next_cnt  = 8'd0;
    next_done = 1'b0;
    next_ill  = 1'b0;
    next_to   = timeout;
    // A wait that runs out without hit parks the sequencer in HALT; hit wins the last cycle.
    if (in_wait && !hit) begin
      if (wait_cnt == WAIT_LAST) begin
        next_addr = HALT;
        next_to   = 1'b1;
      end else begin
        next_cnt = wait_cnt + 8'd1;
      end
    end
    case (addr_ins)
      FETCH1:     next_addr = FETCH_WAIT;
      FETCH_WAIT: if (hit) next_addr = FETCH3;
      FETCH3:     next_addr = FETCH4;
      FETCH4: begin
        next_op   = ir_opcode;
        next_addr = INCPC;
        next_ill  = !op_valid(ir_opcode);
      end
      INCPC: begin
        next_step = 3'd0;
        case (op)
          OP_LOAD:  next_addr = LOAD0;
          OP_STORE: next_addr = STORE0;
          OP_GOTOZ: next_addr = GOTOZ0;
          OP_HALT:  next_addr = HALT;
          default:  next_addr = (lin_steps(op) != 3'd0) ? {1'b0, op, 3'd0} : FETCH1;
        endcase
      end
      LOAD0:      next_addr = LOAD_WAIT;
      LOAD_WAIT:  if (hit) next_addr = LOAD_R1;
      LOAD_R1:    next_addr = LOAD_R2;
      LOAD_R2:    next_addr = LOAD_R3;
      STORE0:     next_addr = STORE1;
      STORE1:     next_addr = STORE2;
      STORE2:     next_addr = STORE_WAIT;
      GOTOZ0:     next_addr = zero ? GOTOZ_Z : GOTOZ_NZ;
      HALT:       next_addr = HALT;
      LOAD_R3, GOTOZ_Z, GOTOZ_NZ: begin
        next_addr = FETCH1;
        next_done = 1'b1;
      end
      STORE_WAIT: if (hit) begin
        next_addr = FETCH1;
        next_done = 1'b1;
      end
      default: begin
        if (lin_steps(op) != 3'd0 && addr_ins[7:3] == op) begin
          if (step == lin_steps(op) - 3'd1) begin
            next_addr = FETCH1;
            next_step = 3'd0;
            next_done = 1'b1;
          end else begin
            next_step = step + 3'd1;
            next_addr = {1'b0, op, step + 3'd1};
          end
        end else begin
          next_addr = FETCH1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_ins   <= FETCH1;
      op         <= 5'd0;
      step       <= 3'd0;
      wait_cnt   <= 8'd0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
    end else if (en) begin
      addr_ins   <= next_addr;
      op         <= next_op;
      step       <= next_step;
      wait_cnt   <= next_cnt;
      instr_done <= next_done;
      illegal    <= next_ill;
      timeout    <= next_to;
    end else begin
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end
  end

endmodule
